// File: rtl/sfx_scheduler_pkg.sv
// Shared types and defaults for the sound-effect scheduler.
package sfx_scheduler_pkg;

    // Scheduler FSM encoding; also exported on the debug state port.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam int          FW_DEF      = 26;
    // Never zero: the downstream divider divides by the frequency word.
    localparam logic [25:0] SILENCE_DEF = 26'd20000;

    // Index width for an n-entry vector, at least one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sfx_scheduler_prio_pick.sv
// Fixed-priority picker: lowest set bit of a request vector wins.
module sfx_scheduler_prio_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  vec_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    // Scan from the top so the lowest set index is the last to write idx_o.
    always_comb begin
        valid_o = |vec_i;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: passes BGM through while idle, lets a granted effect
// own both channels for its programmed length, then inserts a silent gap.
//
// Handshake: sfx_req_i is a 1-cycle pulse with no ready; the request is
// latched into pending_o that same cycle and stays there until granted, so
// a requester never needs to hold or repeat its pulse.
module sfx_scheduler
    import sfx_scheduler_pkg::*;
#(
    parameter int          NREQ    = 4,
    parameter int          FW      = FW_DEF,
    parameter int          LW      = 12,
    parameter int          GAP     = 2,
    parameter logic [FW-1:0] SILENCE = SILENCE_DEF,
    localparam int         IW      = idx_w(NREQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tick_i,
    input  logic                 mute_i,
    input  logic [FW-1:0]        bgm_freq_l_i,
    input  logic [FW-1:0]        bgm_freq_r_i,
    input  logic [NREQ-1:0]      sfx_req_i,
    input  logic [NREQ*FW-1:0]   sfx_freq_i,
    input  logic [NREQ*LW-1:0]   sfx_len_i,
    output logic [FW-1:0]        freq_l_o,
    output logic [FW-1:0]        freq_r_o,
    output logic                 busy_o,
    output logic [IW-1:0]        grant_id_o,
    output logic [NREQ-1:0]      pending_o,
    output state_t               state_o
);

    logic [FW-1:0]   freq_a [NREQ];
    logic [LW-1:0]   len_a  [NREQ];
    logic [NREQ-1:0] pend_all;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;

    state_t          state_q,   state_d;
    logic [IW-1:0]   grant_q,   grant_d;
    logic [LW-1:0]   cnt_q,     cnt_d;
    logic [NREQ-1:0] pending_q, pending_d;
    logic [FW-1:0]   freq_l_q,  freq_l_d;
    logic [FW-1:0]   freq_r_q,  freq_r_d;

    // Split the flat per-requester buses into indexable arrays.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign freq_a[g] = sfx_freq_i[g*FW +: FW];
        assign len_a[g]  = sfx_len_i[g*LW +: LW];
    end

    // Same-cycle requests count as pending so a grant never waits a cycle.
    assign pend_all = pending_q | sfx_req_i;

    sfx_scheduler_prio_pick #(.N(NREQ), .IW(IW)) u_pick (
        .vec_i   (pend_all),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Next-state logic: grant, preemption, length and gap counting.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        pending_d = pend_all;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d             = S_PLAY;
                    grant_d             = pick_idx;
                    cnt_d               = len_a[pick_idx];
                    pending_d[pick_idx] = 1'b0;
                end
            end
            S_PLAY: begin
                if (pick_valid && (pick_idx < grant_q)) begin
                    // Higher priority cuts in; the current effect is dropped.
                    grant_d             = pick_idx;
                    cnt_d               = len_a[pick_idx];
                    pending_d[pick_idx] = 1'b0;
                end else if (tick_i) begin
                    if (cnt_q <= LW'(1)) begin
                        grant_d = '0;
                        if (GAP > 0) begin
                            state_d = S_GAP;
                            cnt_d   = LW'(GAP);
                        end else begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - LW'(1);
                    end
                end
            end
            S_GAP: begin
                if (tick_i) begin
                    if (cnt_q <= LW'(1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - LW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output selection from the upcoming state; mute only replaces the value.
    always_comb begin
        freq_l_d = SILENCE;
        freq_r_d = SILENCE;
        if (!mute_i) begin
            if (state_d == S_IDLE) begin
                freq_l_d = bgm_freq_l_i;
                freq_r_d = bgm_freq_r_i;
            end else if (state_d == S_PLAY) begin
                freq_l_d = freq_a[grant_d];
                freq_r_d = freq_a[grant_d];
            end
        end
    end

    // State, counter, pending and registered output frequencies.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            freq_l_q  <= SILENCE;
            freq_r_q  <= SILENCE;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            freq_l_q  <= freq_l_d;
            freq_r_q  <= freq_r_d;
        end
    end

    assign freq_l_o   = freq_l_q;
    assign freq_r_o   = freq_r_q;
    assign busy_o     = (state_q != S_IDLE);
    assign grant_id_o = grant_q;
    assign pending_o  = pending_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler with an expected-output queue.
module tb_sfx_scheduler;
  import sfx_scheduler_pkg::*;

  localparam int EW = 59;  // {freq_l[26], freq_r[26], busy, grant_id[2], pending[4]}
  localparam logic [25:0] SIL = 26'd20000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          tick = 1'b0;
  logic          mute = 1'b0;
  logic [25:0]   bgm_l = 26'd440;
  logic [25:0]   bgm_r = 26'd262;
  logic [3:0]    sfx_req = 4'b0000;
  logic [103:0]  sfx_freq;
  logic [47:0]   sfx_len;
  logic [25:0]   freq_l, freq_r;
  logic          busy;
  logic [1:0]    grant_id;
  logic [3:0]    pending;
  state_t        state_dbg;

  sfx_scheduler dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tick_i       (tick),
    .mute_i       (mute),
    .bgm_freq_l_i (bgm_l),
    .bgm_freq_r_i (bgm_r),
    .sfx_req_i    (sfx_req),
    .sfx_freq_i   (sfx_freq),
    .sfx_len_i    (sfx_len),
    .freq_l_o     (freq_l),
    .freq_r_o     (freq_r),
    .busy_o       (busy),
    .grant_id_o   (grant_id),
    .pending_o    (pending),
    .state_o      (state_dbg)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int            tag_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            step_no = 0;

  task automatic compare(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got fl=%0d fr=%0d busy=%0b gid=%0d pend=%b, want fl=%0d fr=%0d busy=%0b gid=%0d pend=%b",
               name, act[58:33], act[32:7], act[6], act[5:4], act[3:0],
               exp[58:33], exp[32:7], exp[6], exp[5:4], exp[3:0]);
    end
  endtask

  // monitor: one output snapshot per clock, compared against the queue head
  initial begin
    logic [EW-1:0] e;
    int            t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        compare($sformatf("step%0d", t), {freq_l, freq_r, busy, grant_id, pending}, e);
      end
    end
  end

  // driver: one clock of stimulus plus the hand-computed post-edge outputs
  task automatic step(input logic [3:0] req, input logic tk, input logic mu,
                      input logic [25:0] fl, input logic [25:0] fr,
                      input logic b, input logic [1:0] g, input logic [3:0] p);
    sfx_req = req;
    tick    = tk;
    mute    = mu;
    step_no++;
    exp_q.push_back({fl, fr, b, g, p});
    tag_q.push_back(step_no);
    @(negedge clk);
    sfx_req = 4'b0000;
    tick    = 1'b0;
  endtask

  initial begin
    // requester tones: 0=1500, 1=700, 2=988, 3=330; lengths 2, 2, 3, 10 ticks
    sfx_freq = {26'd330, 26'd988, 26'd700, 26'd1500};
    sfx_len  = {12'd10, 12'd3, 12'd2, 12'd2};

    // asynchronous reset, checked without a clock edge
    #3 rst_n = 1'b0;
    #1 compare("reset", {freq_l, freq_r, busy, grant_id, pending}, {SIL, SIL, 1'b0, 2'd0, 4'b0000});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // idle BGM pass-through
    step(4'b0000, 0, 0, 440, 262, 0, 0, 4'b0000);

    // single effect id 2, 3 ticks, then 2-tick gap
    step(4'b0100, 0, 0, 988, 988, 1, 2, 4'b0000);
    step(4'b0000, 1, 0, 988, 988, 1, 2, 4'b0000);
    step(4'b0000, 0, 0, 988, 988, 1, 2, 4'b0000);
    step(4'b0000, 1, 0, 988, 988, 1, 2, 4'b0000);
    step(4'b0000, 1, 0, SIL, SIL, 1, 0, 4'b0000);
    step(4'b0000, 1, 0, SIL, SIL, 1, 0, 4'b0000);
    step(4'b0000, 1, 0, 440, 262, 0, 0, 4'b0000);
    step(4'b0000, 0, 0, 440, 262, 0, 0, 4'b0000);

    // simultaneous requests 1 and 3: 1 first, 3 after gap (one BGM cycle between)
    step(4'b1010, 0, 0, 700, 700, 1, 1, 4'b1000);
    step(4'b0000, 1, 0, 700, 700, 1, 1, 4'b1000);
    step(4'b0000, 1, 0, SIL, SIL, 1, 0, 4'b1000);
    step(4'b0000, 1, 0, SIL, SIL, 1, 0, 4'b1000);
    step(4'b0000, 1, 0, 440, 262, 0, 0, 4'b1000);
    step(4'b0000, 0, 0, 330, 330, 1, 3, 4'b0000);

    // id 3 playing; request 0 together with the 4th tick preempts
    step(4'b0000, 1, 0, 330, 330, 1, 3, 4'b0000);
    step(4'b0000, 1, 0, 330, 330, 1, 3, 4'b0000);
    step(4'b0000, 1, 0, 330, 330, 1, 3, 4'b0000);
    step(4'b0001, 1, 0, 1500, 1500, 1, 0, 4'b0000);

    // lower priority waits; mute silences but the effect keeps counting
    step(4'b0100, 0, 0, 1500, 1500, 1, 0, 4'b0100);
    step(4'b0000, 1, 1, SIL, SIL, 1, 0, 4'b0100);
    step(4'b0000, 0, 0, 1500, 1500, 1, 0, 4'b0100);
    step(4'b0000, 1, 0, SIL, SIL, 1, 0, 4'b0100);

    // higher-priority request during the gap does not cut it
    step(4'b0001, 1, 0, SIL, SIL, 1, 0, 4'b0101);
    step(4'b0000, 1, 0, 440, 262, 0, 0, 4'b0101);
    step(4'b0000, 0, 0, 1500, 1500, 1, 0, 4'b0100);

    // re-request of the playing id replays after gap
    step(4'b0001, 0, 0, 1500, 1500, 1, 0, 4'b0101);
    step(4'b0000, 1, 0, 1500, 1500, 1, 0, 4'b0101);
    step(4'b0000, 1, 0, SIL, SIL, 1, 0, 4'b0101);
    step(4'b0000, 1, 0, SIL, SIL, 1, 0, 4'b0101);
    step(4'b0000, 1, 0, 440, 262, 0, 0, 4'b0101);
    step(4'b0000, 0, 0, 1500, 1500, 1, 0, 4'b0100);
    step(4'b0000, 1, 0, 1500, 1500, 1, 0, 4'b0100);

    // tone is sampled live while playing
    sfx_freq[25:0] = 26'd1600;
    step(4'b0011, 0, 0, 1600, 1600, 1, 0, 4'b0111);

    // asynchronous reset mid-effect drops everything
    #3 rst_n = 1'b0;
    #1 compare("reset_mid_play", {freq_l, freq_r, busy, grant_id, pending}, {SIL, SIL, 1'b0, 2'd0, 4'b0000});
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0000, 0, 0, 440, 262, 0, 0, 4'b0000);

    repeat (2) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d queued, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
